// File: rtl/icache_pkg.sv
// Shared definitions for the L1 instruction cache: FSM encoding, default
// geometry, derived field widths and an address-field extraction helper.
package icache_pkg;

    // Default cache geometry (64 lines x 4 beats x 64 bits, 32-bit physical tag space).
    localparam int DEF_NUM_LINES  = 64;
    localparam int DEF_LINE_BEATS = 4;
    localparam int DEF_PADDR_W    = 32;

    // Derived field widths for the default geometry.
    localparam int WORD_W   = $clog2(DEF_LINE_BEATS);
    localparam int INDEX_W  = $clog2(DEF_NUM_LINES);
    localparam int OFFSET_W = WORD_W + 3;
    localparam int TAG_W    = DEF_PADDR_W - OFFSET_W - INDEX_W;

    // Cache enable/bypass selection, kept next to the core-level defines.
    localparam bit ICACHE_ENABLE = 1'b1;
    localparam bit ICACHE_BYPASS = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        RESP
    } state_t;

    // Returns addr[lsb +: width], zero-extended to 64 bits.
    function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (addr >> lsb) & mask;
    endfunction

endpackage

// File: rtl/icache_l1_if.sv
// Fetch-side and memory-side handshake bundle of the L1 instruction cache.
// The cache uses the slave modport; the fetch stage / memory bus use master.
interface icache_l1_if;
    logic [63:0] im_req_addr;
    logic        im_req_valid;
    logic        im_req_ready;
    logic [63:0] im_resp_rdata;
    logic        im_resp_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_resp_rdata;
    logic        mem_resp_valid;

    modport slave (
        input  im_req_addr, im_req_valid, mem_req_ready, mem_resp_rdata, mem_resp_valid,
        output im_req_ready, im_resp_rdata, im_resp_valid, mem_req_addr, mem_req_valid
    );

    modport master (
        output im_req_addr, im_req_valid, mem_req_ready, mem_resp_rdata, mem_resp_valid,
        input  im_req_ready, im_resp_rdata, im_resp_valid, mem_req_addr, mem_req_valid
    );
endinterface

// File: rtl/icache_ram.sv
// Simple-dual-port synchronous RAM with registered read; contents not reset.
module icache_ram #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/icache_l1.sv
// Direct-mapped blocking L1 instruction cache. Hits respond one cycle after
// acceptance; misses refill a whole line in LINE_BEATS 64-bit beats.
// Optional macro ICACHE_PERF_EN adds saturating performance counters.
module icache_l1 import icache_pkg::*; #(
    parameter int NUM_LINES  = DEF_NUM_LINES,
    parameter int LINE_BEATS = DEF_LINE_BEATS,
    parameter int PADDR_W    = DEF_PADDR_W
) (
    input  logic        clk,
    input  logic        rst_n,
    icache_l1_if.slave  bus,
    input  logic        ic_invalidate
`ifdef ICACHE_PERF_EN
    ,
    input  logic        perf_clear,
    output logic [63:0] perf_access,
    output logic [63:0] perf_miss,
    output logic [63:0] perf_refill_cycles
`endif
);
    localparam int WORD_BITS  = $clog2(LINE_BEATS);
    localparam int INDEX_BITS = $clog2(NUM_LINES);
    localparam int OFF_BITS   = WORD_BITS + 3;
    localparam int TAG_BITS   = PADDR_W - OFF_BITS - INDEX_BITS;
    localparam int DADDR_W    = INDEX_BITS + WORD_BITS;

    state_t                 state_reg;
    logic [63:0]            addr_reg;
    logic [WORD_BITS-1:0]   beat_reg;
    logic [63:0]            resp_data_reg;
    logic                   mem_req_valid_reg;
    logic [63:0]            mem_req_addr_reg;
    logic [NUM_LINES-1:0]   valid_reg;
    logic                   inv_pending_reg;

    logic [INDEX_BITS-1:0]  req_index, cur_index;
    logic [WORD_BITS-1:0]   req_word, cur_word;
    logic [TAG_BITS-1:0]    cur_tag, tag_rd;
    logic [63:0]            data_rd;
    logic                   hit, req_ready, accept, refill_beat, last_beat, clear_all;

    assign req_index = INDEX_BITS'(addr_field(bus.im_req_addr, OFF_BITS, INDEX_BITS));
    assign req_word  = WORD_BITS'(addr_field(bus.im_req_addr, 3, WORD_BITS));
    assign cur_index = INDEX_BITS'(addr_field(addr_reg, OFF_BITS, INDEX_BITS));
    assign cur_word  = WORD_BITS'(addr_field(addr_reg, 3, WORD_BITS));
    assign cur_tag   = TAG_BITS'(addr_field(addr_reg, OFF_BITS + INDEX_BITS, TAG_BITS));

    // Valid bits are read in LOOKUP before any clear taking effect at the same edge.
    assign hit         = (state_reg == LOOKUP) && valid_reg[cur_index] && (tag_rd == cur_tag);
    assign req_ready   = rst_n && (((state_reg == IDLE) && !ic_invalidate && !inv_pending_reg) || hit);
    assign accept      = bus.im_req_valid && req_ready;
    assign refill_beat = (state_reg == REFILL) && bus.mem_resp_valid;
    assign last_beat   = refill_beat && (beat_reg == WORD_BITS'(LINE_BEATS - 1));
    // A deferred invalidate lands as RESP is left, covering the line just filled.
    assign clear_all   = (((state_reg == IDLE) || (state_reg == LOOKUP)) && ic_invalidate) ||
                         ((state_reg == RESP) && (inv_pending_reg || ic_invalidate));

    assign bus.im_req_ready  = req_ready;
    assign bus.im_resp_valid = hit || (state_reg == RESP);
    assign bus.im_resp_rdata = (state_reg == LOOKUP) ? data_rd : resp_data_reg;
    assign bus.mem_req_valid = mem_req_valid_reg;
    assign bus.mem_req_addr  = mem_req_addr_reg;

    icache_ram #(.DEPTH(NUM_LINES), .WIDTH(TAG_BITS), .ADDR_W(INDEX_BITS)) u_tag_ram (
        .clk     (clk),
        .wr_en   (last_beat),
        .wr_addr (cur_index),
        .wr_data (cur_tag),
        .rd_en   (accept),
        .rd_addr (req_index),
        .rd_data (tag_rd)
    );

    icache_ram #(.DEPTH(NUM_LINES * LINE_BEATS), .WIDTH(64), .ADDR_W(DADDR_W)) u_data_ram (
        .clk     (clk),
        .wr_en   (refill_beat),
        .wr_addr ({cur_index, beat_reg}),
        .wr_data (bus.mem_resp_rdata),
        .rd_en   (accept),
        .rd_addr ({req_index, req_word}),
        .rd_data (data_rd)
    );

    // Main control FSM: accept, lookup, refill request, beat collection, response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            addr_reg          <= '0;
            beat_reg          <= '0;
            resp_data_reg     <= '0;
            mem_req_valid_reg <= 1'b0;
            mem_req_addr_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg  <= bus.im_req_addr;
                        state_reg <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (accept) begin
                            addr_reg <= bus.im_req_addr;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        mem_req_valid_reg <= 1'b1;
                        mem_req_addr_reg  <= {addr_reg[63:OFF_BITS], {OFF_BITS{1'b0}}};
                        state_reg         <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_reg <= 1'b0;
                        beat_reg          <= '0;
                        state_reg         <= REFILL;
                    end
                end
                REFILL: begin
                    if (refill_beat) begin
                        if (beat_reg == cur_word) begin
                            resp_data_reg <= bus.mem_resp_rdata;
                        end
                        if (last_beat) begin
                            beat_reg  <= '0;
                            state_reg <= RESP;
                        end else begin
                            beat_reg <= beat_reg + WORD_BITS'(1);
                        end
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Per-line valid bits: set by the last refill beat, cleared wholesale by invalidate.
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg[gi] <= 1'b0;
            end else if (clear_all) begin
                valid_reg[gi] <= 1'b0;
            end else if (last_beat && (cur_index == INDEX_BITS'(gi))) begin
                valid_reg[gi] <= 1'b1;
            end
        end
    end

    // Invalidates arriving during a refill are deferred until RESP is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_pending_reg <= 1'b0;
        end else if (state_reg == RESP) begin
            inv_pending_reg <= 1'b0;
        end else if (ic_invalidate && ((state_reg == MISS_REQ) || (state_reg == REFILL))) begin
            inv_pending_reg <= 1'b1;
        end
    end

`ifdef ICACHE_PERF_EN
    // Saturating access / miss / refill-cycle counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_access        <= '0;
            perf_miss          <= '0;
            perf_refill_cycles <= '0;
        end else if (perf_clear) begin
            perf_access        <= '0;
            perf_miss          <= '0;
            perf_refill_cycles <= '0;
        end else begin
            if (accept && (perf_access != '1)) begin
                perf_access <= perf_access + 64'd1;
            end
            if ((state_reg == LOOKUP) && !hit && (perf_miss != '1)) begin
                perf_miss <= perf_miss + 64'd1;
            end
            if (((state_reg == MISS_REQ) || (state_reg == REFILL)) && (perf_refill_cycles != '1)) begin
                perf_refill_cycles <= perf_refill_cycles + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_l1.sv
// Scoreboard testbench for icache_l1: stimulus pushes expected fetch
// responses and refill addresses; a monitor pops and compares them.
module tb_icache_l1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ic_invalidate = 1'b0;
`ifdef ICACHE_PERF_EN
    logic        perf_clear = 1'b0;
    logic [63:0] perf_access, perf_miss, perf_refill_cycles;
`endif

    icache_l1_if bus();

    icache_l1 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .ic_invalidate (ic_invalidate)
`ifdef ICACHE_PERF_EN
        ,
        .perf_clear         (perf_clear),
        .perf_access        (perf_access),
        .perf_miss          (perf_miss),
        .perf_refill_cycles (perf_refill_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_resp_q[$];
    logic [63:0] exp_mem_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every fetch response and every refill handshake is matched against the queues.
    always @(negedge clk) begin
        if (rst_n && bus.im_resp_valid) begin
            if (exp_resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got %h expected none", bus.im_resp_rdata);
            end else begin
                $display("resp  data=%h", bus.im_resp_rdata);
                chk("resp_data", bus.im_resp_rdata, exp_resp_q.pop_front());
            end
        end
        if (rst_n && bus.mem_req_valid && bus.mem_req_ready) begin
            if (exp_mem_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mem_req: got %h expected none", bus.mem_req_addr);
            end else begin
                $display("memrq addr=%h", bus.mem_req_addr);
                chk("mem_req_addr", bus.mem_req_addr, exp_mem_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_im_req_ready"},  64'(bus.im_req_ready), 64'd0);
        chk({tag, "_im_resp_valid"}, 64'(bus.im_resp_valid), 64'd0);
        chk({tag, "_mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
        chk({tag, "_mem_req_addr"},  bus.mem_req_addr, 64'd0);
        chk({tag, "_im_resp_rdata"}, bus.im_resp_rdata, 64'd0);
    endtask

    // Issue one fetch request and wait (bounded) for it to be accepted.
    task automatic issue(input logic [63:0] addr, input logic [63:0] exp);
        int n;
        n = 0;
        bus.im_req_addr  = addr;
        bus.im_req_valid = 1'b1;
        exp_resp_q.push_back(exp);
        $display("req   addr=%h", addr);
        @(negedge clk);
        while (!bus.im_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("req_accept", 64'(bus.im_req_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.im_req_valid = 1'b0;
    endtask

    // Memory model: wait for the refill request, stall, then deliver nbeats beats (beat b = pat*(b+1)).
    task automatic refill(input logic [63:0] line, input logic [63:0] pat, input int stall,
                          input int inv_beat, input int nbeats);
        int n;
        logic [63:0] a0;
        n = 0;
        @(negedge clk);
        while (!bus.mem_req_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mem_req_valid_seen", 64'(bus.mem_req_valid), 64'd1);
        chk("mem_req_addr_seen", bus.mem_req_addr, line);
        a0 = bus.mem_req_addr;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
            chk("stall_mem_req_addr", bus.mem_req_addr, a0);
            chk("stall_im_req_ready", 64'(bus.im_req_ready), 64'd0);
        end
        tick();
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_rdata = pat * 64'(b + 1);
            ic_invalidate = (inv_beat >= 0) && ((b == inv_beat) || (b == inv_beat + 1));
            @(negedge clk);
            chk("refill_no_resp", 64'(bus.im_resp_valid), 64'd0);
            chk("refill_im_req_ready", 64'(bus.im_req_ready), 64'd0);
            tick();
        end
        bus.mem_resp_valid = 1'b0;
        ic_invalidate = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_resp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("resp_drain", 64'(exp_resp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.im_req_addr    = '0;
        bus.im_req_valid   = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;

        // Reset state
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 64'(bus.im_req_ready), 64'd1);
        tick();

        // Cold miss: word 1 of line 0x80000000
        exp_mem_q.push_back(64'h0000_0000_8000_0000);
        issue(64'h0000_0000_8000_0008, 64'h2222_2222_2222_2222);
        refill(64'h0000_0000_8000_0000, 64'h1111_1111_1111_1111, 0, -1, 4);
        wait_drain();

        // Back-to-back hits: 0x80000018 (word 3) then 0x80000000 (word 0)
        exp_resp_q.push_back(64'h4444_4444_4444_4444);
        bus.im_req_addr  = 64'h0000_0000_8000_0018;
        bus.im_req_valid = 1'b1;
        $display("req   addr=%h", bus.im_req_addr);
        @(negedge clk);
        chk("hit_a_ready", 64'(bus.im_req_ready), 64'd1);
        tick();
        exp_resp_q.push_back(64'h1111_1111_1111_1111);
        bus.im_req_addr = 64'h0000_0000_8000_0000;
        $display("req   addr=%h", bus.im_req_addr);
        @(negedge clk);
        chk("hit_a_n1_valid", 64'(bus.im_resp_valid), 64'd1);
        chk("hit_b_ready", 64'(bus.im_req_ready), 64'd1);
        tick();
        bus.im_req_valid = 1'b0;
        @(negedge clk);
        chk("hit_b_n2_valid", 64'(bus.im_resp_valid), 64'd1);
        tick();
        @(negedge clk);
        chk("hit_done_valid", 64'(bus.im_resp_valid), 64'd0);
        chk("hit_no_mem_req", 64'(bus.mem_req_valid), 64'd0);
        tick();

        // Conflict miss with a 5-cycle bus stall, then the original line misses again
        exp_mem_q.push_back(64'h0000_0000_8000_0800);
        issue(64'h0000_0000_8000_0800, 64'h0A0A_0A0A_0A0A_0A0A);
        refill(64'h0000_0000_8000_0800, 64'h0A0A_0A0A_0A0A_0A0A, 5, -1, 4);
        wait_drain();
        exp_mem_q.push_back(64'h0000_0000_8000_0000);
        issue(64'h0000_0000_8000_0000, 64'h1111_1111_1111_1111);
        refill(64'h0000_0000_8000_0000, 64'h1111_1111_1111_1111, 0, -1, 4);
        wait_drain();

        // Invalidate in IDLE blocks ready and drops the line
        ic_invalidate = 1'b1;
        @(negedge clk);
        chk("inv_idle_ready", 64'(bus.im_req_ready), 64'd0);
        tick();
        ic_invalidate = 1'b0;
        exp_mem_q.push_back(64'h0000_0000_8000_0000);
        issue(64'h0000_0000_8000_0010, 64'h3333_3333_3333_3333);
        // Two invalidate pulses during the refill: response still delivered, one clear after
        refill(64'h0000_0000_8000_0000, 64'h1111_1111_1111_1111, 0, 1, 4);
        wait_drain();
        @(negedge clk);
        chk("inv_pending_cleared_ready", 64'(bus.im_req_ready), 64'd1);
        tick();
        exp_mem_q.push_back(64'h0000_0000_8000_0000);
        issue(64'h0000_0000_8000_0008, 64'h2222_2222_2222_2222);
        refill(64'h0000_0000_8000_0000, 64'h1111_1111_1111_1111, 0, -1, 4);
        wait_drain();
        issue(64'h0000_0000_8000_0018, 64'h4444_4444_4444_4444);
        wait_drain();

        // Reset after two refill beats
        exp_mem_q.push_back(64'h0000_0000_8000_0040);
        issue(64'h0000_0000_8000_0040, 64'h5555_5555_5555_5555);
        refill(64'h0000_0000_8000_0040, 64'h5555_5555_5555_5555, 0, -1, 2);
        rst_n = 1'b0;
        void'(exp_resp_q.pop_back());
        @(negedge clk);
        check_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        chk("stray_beat_no_resp", 64'(bus.im_resp_valid), 64'd0);
        tick();
        bus.mem_resp_valid = 1'b0;
        exp_mem_q.push_back(64'h0000_0000_8000_0040);
        issue(64'h0000_0000_8000_0048, 64'hAAAA_AAAA_AAAA_AAAA);
        refill(64'h0000_0000_8000_0040, 64'h5555_5555_5555_5555, 0, -1, 4);
        wait_drain();

        tick();
        tick();
        chk("mem_queue_empty", 64'(exp_mem_q.size()), 64'd0);
        chk("resp_queue_empty", 64'(exp_resp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_l1.md
Name: icache_l1

Overview:
- Direct-mapped, blocking L1 instruction cache; sits directly upstream of the instruction fetch pipeline and serves its I-mem request/response port.
- Hits return a 64-bit fetch word one cycle after acceptance, the latency the fetch pipeline expects.
- Misses refill a full line from the memory bus in a fixed number of 64-bit beats.
- Supports a whole-cache invalidate for fence.i.

Parameters:
- NUM_LINES, 64, number of cache lines; power of 2.
- LINE_BEATS, 4, 64-bit beats per line (32-byte line); power of 2.
- PADDR_W, 32, physical address bits used for tag; upper address bits are ignored.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- im_req_addr  in  64  fetch address (byte), from fetch stage
- im_req_valid  in  1  fetch request valid
- im_req_ready  out  1  cache can accept request
- im_resp_rdata  out  64  aligned 64-bit word containing addressed instruction
- im_resp_valid  out  1  response valid, exactly one per accepted request
- mem_req_addr  out  64  line-aligned refill address
- mem_req_valid  out  1  refill request valid
- mem_req_ready  in  1  bus accepted refill request
- mem_resp_rdata  in  64  refill beat, ascending address order
- mem_resp_valid  in  1  refill beat valid
- ic_invalidate  in  1  single-cycle pulse: invalidate all lines

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Address split: offset [2:0] ignored; word = [log2(LINE_BEATS)+2:3]; index = next log2(NUM_LINES) bits; tag = remaining bits up to PADDR_W-1. Defaults: word [4:3], index [10:5], tag [31:11].
- Storage:
  - Valid bits are flops, cleared by reset and invalidate.
  - Tag and data arrays are synchronous-read RAMs, read with the request index in the accept cycle.
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, RESP.
- IDLE:
  - im_req_ready = 1 unless ic_invalidate is high this cycle or an invalidate is pending.
  - Accept on valid&&ready; latch address; go to LOOKUP.
- LOOKUP (cycle N+1 after accept at N):
  - Hit = valid[index] && tag match.
  - Hit: im_resp_valid = 1 with RAM word; im_req_ready = 1, so back-to-back accept is allowed and the next hit response comes at N+2.
  - Miss: im_resp_valid = 0; go to MISS_REQ.
- MISS_REQ:
  - mem_req_valid = 1, mem_req_addr = {addr[63:line_bits], zeros}.
  - Hold address until mem_req_ready, then go to REFILL.
- REFILL:
  - Beat counter 0..LINE_BEATS-1; each mem_resp_valid writes the data RAM at {index, counter}.
  - The beat whose counter equals the request word is captured into a response register.
  - After the last beat, write the tag, set valid[index] and go to RESP.
- RESP: im_resp_valid = 1 with the captured word for exactly one cycle, then IDLE.
- im_req_ready = 0 in MISS_REQ, REFILL and RESP.
- Invalidate:
  - In IDLE or LOOKUP: all valid bits clear at the next edge. A LOOKUP in the same cycle still completes using the pre-clear state.
  - In MISS_REQ, REFILL or RESP: set a pending flag. The refill completes and its response is delivered; in the cycle RESP is left, all valids clear, including the just-filled line.
  - ic_invalidate pulses while a flag is pending are absorbed; a single clear covers them.
- mem_resp_valid outside REFILL is ignored.
- Reset values:
  - im_req_ready = 0 while rst_n low, 1 after.
  - im_resp_valid = 0, mem_req_valid = 0, mem_req_addr = 0, im_resp_rdata = 0.
  - State IDLE; all valid bits 0; pending invalidate 0; beat counter 0.
- Reset mid-refill: abandons the refill with no valid set. The bus is reset by the same rst_n; beats arriving after reset are ignored.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- When defined: adds 64-bit saturating counters perf_access, perf_miss and perf_refill_cycles (cycles spent in MISS_REQ plus REFILL), exposed as outputs.
  - The counters clear on reset and on a perf_clear input pulse.
- When undefined: those ports and counters do not exist, and timing is identical.

Decomposition:
- Shared package icache_pkg holds:
  - FSM state encoding.
  - Derived widths (WORD_W, INDEX_W, TAG_W) and an address-field extraction function.
  - Cache enable/bypass defines, kept alongside the existing core defines.
- One sub-module, icache_ram: simple-dual-port synchronous RAM (read enable, write enable) for tags and data. It is instantiated twice, with no reset on its contents.

Test Plan:
- Cold miss: reset, request 0x80000008; memory sees addr 0x80000000; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → one im_resp_valid with 0x2222222222222222; exactly one mem request.
- Hit after fill: request 0x80000018 then 0x80000000 back-to-back → responses 0x44..44 at N+1 and 0x11..11 at N+2; no mem_req_valid.
- Conflict: request 0x80000800 (same index, different tag) → miss, refill at 0x80000800; a subsequent 0x80000000 misses again.
- Bus stall: hold mem_req_ready = 0 for 5 cycles → mem_req_valid and mem_req_addr stable; im_req_ready = 0 throughout; response only after 4 beats.
- Invalidate: pulse ic_invalidate during REFILL of 0x80000000 → response delivered; a later request to 0x80000000 misses.
- Reset mid-refill: deassert rst_n after 2 beats → outputs at reset values; re-request of the same line misses and issues a new mem request.
